// File: rtl/pong_ball.sv
// Ball engine for Pong: overlap detection against the paddles, per-frame motion, bounces and scoring.
// Optional BALL_SPEEDUP_EN: each paddle bounce raises horizontal speed up to MAXSPEED.
module pong_ball #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned SIZE         = 8,
    parameter int unsigned XSPEED       = 2,
    parameter int unsigned YSPEED       = 1,
    parameter int unsigned MAXSPEED     = 6,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame,
    input  logic       hit_l,
    input  logic       hit_r,
    input  logic       serve,
    output logic [2:0] color,
    output logic       onball,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0]  CX    = 10'(SCREEN_W / 2 - SIZE / 2);
    localparam logic [9:0]  CY    = 10'(SCREEN_H / 2 - SIZE / 2);
    localparam logic [2:0]  SPD0  = 3'(XSPEED);
    localparam logic [2:0]  SPDM  = 3'(MAXSPEED);
    localparam logic [3:0]  WIN   = 4'(WIN_SCORE);

`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_SERVE,
        ST_PLAY,
        ST_OVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       bx_q, bx_d;
    logic [9:0]       by_q, by_d;
    logic             dx_q, dx_d;
    logic             dy_q, dy_d;
    logic [2:0]       spd_q, spd_d;
    logic [3:0]       score_l_q, score_l_d;
    logic [3:0]       score_r_q, score_r_d;
    logic             hl_q, hl_d;
    logic             hr_q, hr_d;

    logic [10:0] x_w, y_w, bx_end, by_end;
    logic        hl_now, hr_now;
    logic        bounce_l, bounce_r, bounce;
    logic [2:0]  spd_bounce, spd_hit;
    logic        goal_l, goal_r;
    logic        wall_top, wall_bot;
    logic [3:0]  score_l_inc, score_r_inc;

    // Ball square test, 11-bit so the right/bottom edge never wraps
    assign x_w    = {1'b0, x};
    assign y_w    = {1'b0, y};
    assign bx_end = {1'b0, bx_q} + 11'(SIZE);
    assign by_end = {1'b0, by_q} + 11'(SIZE);

    assign onball    = (state_q != ST_OVER) && (x >= bx_q) && (x_w < bx_end)
                       && (y >= by_q) && (y_w < by_end);
    assign color     = onball ? 3'b111 : 3'b000;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign game_over = (state_q == ST_OVER);

    // The frame cycle's own overlap counts before the latches are cleared
    assign hl_now = hl_q | (onball & hit_l);
    assign hr_now = hr_q | (onball & hit_r);
    assign hl_d   = frame ? 1'b0 : hl_now;
    assign hr_d   = frame ? 1'b0 : hr_now;

    assign bounce_l = hl_now && !dx_q;
    assign bounce_r = hr_now && dx_q;
    assign bounce   = bounce_l || bounce_r;

    assign spd_bounce = (spd_q >= SPDM) ? SPDM : spd_q + 3'd1;
    assign spd_hit    = SPEEDUP ? spd_bounce : spd_q;

    assign goal_l = !dx_q && !bounce && (bx_q <= {7'b0, spd_q});
    assign goal_r = dx_q && !bounce
                    && (bx_end + {8'b0, spd_q} >= 11'(SCREEN_W));

    assign wall_top = !dy_q && (by_q <= 10'(YSPEED));
    assign wall_bot = dy_q && (by_end + 11'(YSPEED) >= 11'(SCREEN_H));

    assign score_l_inc = score_l_q + 4'd1;
    assign score_r_inc = score_r_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        spd_d     = spd_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;

        if (frame) begin
            case (state_q)
                ST_SERVE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                        spd_d   = SPD0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                ST_PLAY: begin
                    if (wall_top) begin
                        by_d = '0;
                        dy_d = 1'b1;
                    end else if (wall_bot) begin
                        by_d = 10'(SCREEN_H - SIZE);
                        dy_d = 1'b0;
                    end else begin
                        by_d = dy_q ? by_q + 10'(YSPEED) : by_q - 10'(YSPEED);
                    end

                    // A bounce moves the ball in the new direction within the same frame
                    if (bounce) begin
                        dx_d  = !dx_q;
                        spd_d = spd_hit;
                        bx_d  = dx_q ? bx_q - {7'b0, spd_hit} : bx_q + {7'b0, spd_hit};
                    end else if (goal_l || goal_r) begin
                        bx_d  = CX;
                        by_d  = CY;
                        spd_d = SPD0;
                        cnt_d = CNT_W'(SERVE_FRAMES);
                        if (goal_l) begin
                            score_r_d = score_r_inc;
                            dx_d      = 1'b1;
                            state_d   = (score_r_inc == WIN) ? ST_OVER : ST_SERVE;
                        end else begin
                            score_l_d = score_l_inc;
                            dx_d      = 1'b0;
                            state_d   = (score_l_inc == WIN) ? ST_OVER : ST_SERVE;
                        end
                    end else begin
                        bx_d = dx_q ? bx_q + {7'b0, spd_q} : bx_q - {7'b0, spd_q};
                    end
                end

                ST_OVER: begin
                    if (!serve) begin
                        score_l_d = '0;
                        score_r_d = '0;
                        dx_d      = 1'b1;
                        bx_d      = CX;
                        by_d      = CY;
                        spd_d     = SPD0;
                        cnt_d     = CNT_W'(SERVE_FRAMES);
                        state_d   = ST_SERVE;
                    end
                end

                default: state_d = ST_SERVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_SERVE;
            cnt_q     <= CNT_W'(SERVE_FRAMES);
            bx_q      <= CX;
            by_q      <= CY;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            spd_q     <= SPD0;
            score_l_q <= '0;
            score_r_q <= '0;
            hl_q      <= 1'b0;
            hr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            spd_q     <= spd_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hl_q      <= hl_d;
            hr_q      <= hr_d;
        end
    end

endmodule
